// File: rtl/exc_ctrl_if.sv
// Commit-stage exception bundle: instruction status and CP0 state flow in,
// while the CP0 exception write, the flush and the PC redirect flow out.
interface exc_ctrl_if;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_in_ds;
  logic        m_eret;
  logic        m_exc_if_adel;
  logic        m_exc_ri;
  logic        m_exc_ov;
  logic        m_exc_sys;
  logic        m_exc_bp;
  logic        m_exc_adel;
  logic        m_exc_ades;
  logic [31:0] m_data_addr;
  logic [7:0]  intr_vect;
  logic [31:0] er_epc;
  logic        cp0w_we;
  logic        cp0w_exl;
  logic        cp0w_bd;
  logic [4:0]  cp0w_exc;
  logic [31:0] cp0w_epc;
  logic [31:0] cp0w_bva;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Pipeline side: drives commit status, consumes the controller's decisions.
  modport master (
    output m_valid, m_pc, m_in_ds, m_eret, m_exc_if_adel, m_exc_ri, m_exc_ov,
           m_exc_sys, m_exc_bp, m_exc_adel, m_exc_ades, m_data_addr,
           intr_vect, er_epc,
    input  cp0w_we, cp0w_exl, cp0w_bd, cp0w_exc, cp0w_epc, cp0w_bva,
           flush, redirect_valid, redirect_pc
  );

  // Controller side.
  modport slave (
    input  m_valid, m_pc, m_in_ds, m_eret, m_exc_if_adel, m_exc_ri, m_exc_ov,
           m_exc_sys, m_exc_bp, m_exc_adel, m_exc_ades, m_data_addr,
           intr_vect, er_epc,
    output cp0w_we, cp0w_exl, cp0w_bd, cp0w_exc, cp0w_epc, cp0w_bva,
           flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/ERET controller at the commit stage. Prioritises exception causes
// and interrupts, drives the CP0 exception write, flush and PC redirect.
// ERET is split over two cycles so EPC is sampled before it is written back.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ERET2,
    FLUSH
  } state_t;

  localparam logic [3:0] CNT_INIT   = 4'(FLUSH_CYCLES - 1);
  localparam bit         SINGLE_CYC = (FLUSH_CYCLES == 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        int_pending;
  logic        sh_bd;
  logic [4:0]  sh_exc;
  logic [31:0] sh_bva;
  logic [31:0] epc_hold;

  logic        eff_valid;
  logic        int_hit;
  logic        exc_any;
  logic        exc_take;
  logic        eret_take;
  logic [4:0]  exc_code;
  logic [31:0] exc_bva;
  logic [31:0] exc_epc;

  logic        we;
  logic        exl;
  logic        bd;
  logic [4:0]  exc;
  logic [31:0] epc;
  logic [31:0] bva;
  logic        flush;
  logic        rv;
  logic [31:0] rpc;

  // Cause prioritisation for the instruction in the commit slot.
  always_comb begin
    eff_valid = bus.m_valid && (state == IDLE);
    int_hit   = int_pending || (bus.intr_vect != '0);
    exc_any   = 1'b1;
    exc_code  = '0;
    exc_bva   = sh_bva;
    if (int_hit) begin
      exc_code = 5'h00;
    end else if (bus.m_exc_if_adel) begin
      exc_code = 5'h04;
      exc_bva  = bus.m_pc;
    end else if (bus.m_exc_ri) begin
      exc_code = 5'h0a;
    end else if (bus.m_exc_ov) begin
      exc_code = 5'h0c;
    end else if (bus.m_exc_sys) begin
      exc_code = 5'h08;
    end else if (bus.m_exc_bp) begin
      exc_code = 5'h09;
    end else if (bus.m_exc_adel) begin
      exc_code = 5'h04;
      exc_bva  = bus.m_data_addr;
    end else if (bus.m_exc_ades) begin
      exc_code = 5'h05;
      exc_bva  = bus.m_data_addr;
    end else begin
      exc_any  = 1'b0;
    end
    exc_epc   = bus.m_in_ds ? (bus.m_pc - 32'd4) : bus.m_pc;
    exc_take  = eff_valid && exc_any;
    eret_take = eff_valid && bus.m_eret && !exc_any;
  end

  // Output bundle; reset forces everything quiet so an aborted ERET never writes CP0.
  always_comb begin
    we    = 1'b0;
    exl   = 1'b0;
    bd    = 1'b0;
    exc   = '0;
    epc   = '0;
    bva   = '0;
    flush = 1'b0;
    rv    = 1'b0;
    rpc   = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (exc_take) begin
            we    = 1'b1;
            exl   = 1'b1;
            bd    = bus.m_in_ds;
            exc   = exc_code;
            epc   = exc_epc;
            bva   = exc_bva;
            flush = 1'b1;
            rv    = 1'b1;
            rpc   = EXC_VECTOR;
          end else if (eret_take) begin
            flush = 1'b1;
          end
        end
        ERET2: begin
          we    = 1'b1;
          bd    = sh_bd;
          exc   = sh_exc;
          epc   = epc_hold;
          bva   = sh_bva;
          flush = 1'b1;
          rv    = 1'b1;
          rpc   = epc_hold;
        end
        FLUSH: begin
          flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.cp0w_we        = we;
  assign bus.cp0w_exl       = exl;
  assign bus.cp0w_bd        = bd;
  assign bus.cp0w_exc       = exc;
  assign bus.cp0w_epc       = epc;
  assign bus.cp0w_bva       = bva;
  assign bus.flush          = flush;
  assign bus.redirect_valid = rv;
  assign bus.redirect_pc    = rpc;

  // Sequencing, flush countdown, interrupt latch and shadow copies of CP0 writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      int_pending <= 1'b0;
      sh_bd       <= 1'b0;
      sh_exc      <= '0;
      sh_bva      <= '0;
      epc_hold    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_take) begin
            sh_bd       <= bus.m_in_ds;
            sh_exc      <= exc_code;
            sh_bva      <= exc_bva;
            int_pending <= 1'b0;
            cnt         <= CNT_INIT;
            state       <= SINGLE_CYC ? IDLE : FLUSH;
          end else begin
            int_pending <= (bus.intr_vect != '0);
            if (eret_take) begin
              epc_hold <= bus.er_epc;
              state    <= ERET2;
            end
          end
        end
        ERET2: begin
          cnt   <= CNT_INIT;
          state <= SINGLE_CYC ? IDLE : FLUSH;
        end
        FLUSH: begin
          if (cnt <= 4'd1) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: a cycle-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_exc_ctrl;

  localparam int unsigned FC  = 3;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  exc_ctrl_if bus ();

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: remaining pure-flush cycles, pending ERET writeback, latched irq, shadows.
  int          md_busy = 0;
  bit          md_eret2 = 0;
  bit          md_pend = 0;
  bit          md_bd = 0;
  logic [4:0]  md_exc = '0;
  logic [31:0] md_bva = '0;
  logic [31:0] md_hold = '0;
  int          codes[8] = '{0, 4, 10, 12, 8, 9, 4, 5};

  always @(negedge clk) begin
    logic        e_we, e_exl, e_bd, e_fl, e_rv;
    logic [4:0]  e_exc;
    logic [31:0] e_epc, e_bva, e_rpc;
    logic [7:0]  causes;
    int          hit;
    e_we = 0; e_exl = 0; e_bd = 0; e_fl = 0; e_rv = 0;
    e_exc = '0; e_epc = '0; e_bva = '0; e_rpc = '0;
    causes = {bus.m_exc_ades, bus.m_exc_adel, bus.m_exc_bp, bus.m_exc_sys,
              bus.m_exc_ov, bus.m_exc_ri, bus.m_exc_if_adel,
              md_pend || (bus.intr_vect != 0)};
    hit = -1;
    for (int i = 7; i >= 0; i--) if (causes[i]) hit = i;

    if (rst) begin
      md_busy = 0; md_eret2 = 0; md_pend = 0;
      md_bd = 0; md_exc = '0; md_bva = '0; md_hold = '0;
    end else if (md_eret2) begin
      e_we = 1; e_bd = md_bd; e_exc = md_exc; e_bva = md_bva;
      e_epc = md_hold; e_fl = 1; e_rv = 1; e_rpc = md_hold;
      md_eret2 = 0;
      md_busy = FC - 1;
    end else if (md_busy > 0) begin
      e_fl = 1;
      md_busy--;
    end else if (bus.m_valid && hit >= 0) begin
      e_we = 1; e_exl = 1; e_bd = bus.m_in_ds; e_exc = 5'(codes[hit]);
      e_epc = bus.m_in_ds ? bus.m_pc - 4 : bus.m_pc;
      e_bva = (hit == 1) ? bus.m_pc : (hit >= 6) ? bus.m_data_addr : md_bva;
      e_fl = 1; e_rv = 1; e_rpc = VEC;
      md_bd = e_bd; md_exc = e_exc; md_bva = e_bva;
      md_pend = 0;
      md_busy = FC - 1;
    end else begin
      if (bus.m_valid && bus.m_eret) begin
        e_fl = 1;
        md_hold = bus.er_epc;
        md_eret2 = 1;
      end
      md_pend = (bus.intr_vect != 0);
    end

    chk("m_we",    32'(bus.cp0w_we),        32'(e_we));
    chk("m_exl",   32'(bus.cp0w_exl),       32'(e_exl));
    chk("m_bd",    32'(bus.cp0w_bd),        32'(e_bd));
    chk("m_exc",   32'(bus.cp0w_exc),       32'(e_exc));
    chk("m_epc",   bus.cp0w_epc,            e_epc);
    chk("m_bva",   bus.cp0w_bva,            e_bva);
    chk("m_flush", 32'(bus.flush),          32'(e_fl));
    chk("m_rv",    32'(bus.redirect_valid), 32'(e_rv));
    chk("m_rpc",   bus.redirect_pc,         e_rpc);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr();
    bus.m_valid = 0; bus.m_pc = '0; bus.m_in_ds = 0; bus.m_eret = 0;
    bus.m_exc_if_adel = 0; bus.m_exc_ri = 0; bus.m_exc_ov = 0;
    bus.m_exc_sys = 0; bus.m_exc_bp = 0; bus.m_exc_adel = 0;
    bus.m_exc_ades = 0; bus.m_data_addr = '0; bus.intr_vect = '0;
    bus.er_epc = '0;
  endtask

  initial begin
    rst = 1;
    clr();
    nxt(); nxt();
    mid();
    chk("rst_we", 32'(bus.cp0w_we), 0);
    chk("rst_flush", 32'(bus.flush), 0);
    chk("rst_rpc", bus.redirect_pc, 0);
    nxt(); rst = 0;
    mid();
    chk("idle_flush", 32'(bus.flush), 0);

    // Overflow, not in delay slot; commit-slot traffic during flush is ignored.
    nxt(); bus.m_valid = 1; bus.m_exc_ov = 1; bus.m_pc = 32'h80001000;
    mid();
    chk("ov_we", 32'(bus.cp0w_we), 1);
    chk("ov_exc", 32'(bus.cp0w_exc), 32'h0c);
    chk("ov_epc", bus.cp0w_epc, 32'h80001000);
    chk("ov_exl", 32'(bus.cp0w_exl), 1);
    chk("ov_rpc", bus.redirect_pc, 32'hBFC00380);
    chk("ov_flush1", 32'(bus.flush), 1);
    nxt(); bus.m_exc_ov = 0; bus.m_exc_sys = 1;
    mid();
    chk("ov_flush2", 32'(bus.flush), 1);
    chk("ov_ign2", 32'(bus.cp0w_we), 0);
    nxt(); mid();
    chk("ov_flush3", 32'(bus.flush), 1);
    chk("ov_ign3", 32'(bus.cp0w_we), 0);
    nxt(); clr(); mid();
    chk("ov_flush4", 32'(bus.flush), 0);

    // Store address error in a delay slot.
    nxt(); bus.m_valid = 1; bus.m_exc_ades = 1; bus.m_in_ds = 1;
    bus.m_pc = 32'h80000204; bus.m_data_addr = 32'h00001003;
    mid();
    chk("ades_epc", bus.cp0w_epc, 32'h80000200);
    chk("ades_bd", 32'(bus.cp0w_bd), 1);
    chk("ades_exc", 32'(bus.cp0w_exc), 32'h05);
    chk("ades_bva", bus.cp0w_bva, 32'h00001003);
    nxt(); clr(); nxt(); nxt();

    // Latched interrupt beats syscall; flags without m_valid do nothing.
    bus.intr_vect = 8'h04; bus.m_exc_ov = 1;
    mid();
    chk("novalid_we", 32'(bus.cp0w_we), 0);
    chk("novalid_flush", 32'(bus.flush), 0);
    nxt(); mid();
    nxt(); clr(); bus.m_valid = 1; bus.m_exc_sys = 1; bus.m_pc = 32'h80003000;
    mid();
    chk("int_we", 32'(bus.cp0w_we), 1);
    chk("int_exc", 32'(bus.cp0w_exc), 32'h00);
    chk("int_epc", bus.cp0w_epc, 32'h80003000);
    chk("int_bva", bus.cp0w_bva, 32'h00001003);
    nxt(); clr(); nxt(); nxt();
    bus.m_valid = 1; bus.m_pc = 32'h80003004;
    mid();
    chk("int_clr_we", 32'(bus.cp0w_we), 0);

    // ERET: sample EPC, then write back with shadowed Cause/BadVAddr.
    nxt(); bus.m_eret = 1; bus.er_epc = 32'h80002000;
    mid();
    chk("eret_t_flush", 32'(bus.flush), 1);
    chk("eret_t_we", 32'(bus.cp0w_we), 0);
    chk("eret_t_rv", 32'(bus.redirect_valid), 0);
    nxt(); clr();
    mid();
    chk("eret2_we", 32'(bus.cp0w_we), 1);
    chk("eret2_exl", 32'(bus.cp0w_exl), 0);
    chk("eret2_epc", bus.cp0w_epc, 32'h80002000);
    chk("eret2_rpc", bus.redirect_pc, 32'h80002000);
    chk("eret2_exc", 32'(bus.cp0w_exc), 32'h00);
    chk("eret2_bva", bus.cp0w_bva, 32'h00001003);
    nxt(); mid();
    chk("eret_fl3", 32'(bus.flush), 1);
    nxt(); mid();
    chk("eret_fl4", 32'(bus.flush), 1);
    nxt(); mid();
    chk("eret_fl5", 32'(bus.flush), 0);

    // ERET together with RI: exception wins, no writeback cycle.
    nxt(); bus.m_valid = 1; bus.m_eret = 1; bus.m_exc_ri = 1;
    bus.m_pc = 32'h80004000; bus.er_epc = 32'h12345678;
    mid();
    chk("ri_we", 32'(bus.cp0w_we), 1);
    chk("ri_exc", 32'(bus.cp0w_exc), 32'h0a);
    chk("ri_rpc", bus.redirect_pc, 32'hBFC00380);
    nxt(); clr(); mid();
    chk("ri_no_eret2_we", 32'(bus.cp0w_we), 0);
    chk("ri_no_eret2_rv", 32'(bus.redirect_valid), 0);
    nxt(); nxt();

    // Reset during the ERET writeback cycle aborts the sequence.
    bus.m_valid = 1; bus.m_eret = 1; bus.er_epc = 32'h80005000;
    mid();
    chk("rst_eret_t", 32'(bus.flush), 1);
    nxt(); clr(); rst = 1;
    mid();
    chk("rst_eret2_we", 32'(bus.cp0w_we), 0);
    chk("rst_eret2_rv", 32'(bus.redirect_valid), 0);
    nxt(); rst = 0;
    mid();
    chk("post_rst_we", 32'(bus.cp0w_we), 0);
    chk("post_rst_flush", 32'(bus.flush), 0);
    chk("post_rst_rpc", bus.redirect_pc, 0);
    nxt(); mid();
    chk("post_rst_idle", 32'(bus.flush), 0);

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
